cpu_sequencer: RTL and testbench

- Parametrised instruction sequencer: the next-generation CPU control core.
- Fetches 16-bit instructions over a req/ack memory port, decodes the 4-bit opcode and FROM/TO/IF fields, and sequences register-file reads, conditional moves, immediate loads and ALU operations through a generalised data width.
- Drives an external register file and PC. Has proper HALT/resume and illegal-opcode handling, plus a multi-cycle multiplier.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/cpu_seq_alu.sv | 85 ++++++++
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction field helpers for cpu_sequencer.
// CPU_SEQ_MUL_EN enables the MUL opcode; without it opcode D is illegal.
package cpu_pkg;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_MOVNZ = 4'h2;
    localparam logic [3:0] OP_MOVEZ = 4'h3;
    localparam logic [3:0] OP_SET   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_NOT   = 4'hA;
    localparam logic [3:0] OP_ADD   = 4'hB;
    localparam logic [3:0] OP_SHFT  = 4'hC;
    localparam logic [3:0] OP_MUL   = 4'hD;
    localparam logic [3:0] OP_GT    = 4'hE;
    localparam logic [3:0] OP_EQ    = 4'hF;

`ifdef CPU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        IMM    = 4'd2,
        RD_A   = 4'd3,
        RD_B   = 4'd4,
        EXEC   = 4'd5,
        COMMIT = 4'd6,
        HALTED = 4'd7
    } state_e;

    // Word layout: {IF, TO, FROM, INS}, low nibble is the opcode
    function automatic logic [3:0] f_ins(input logic [15:0] w);
        return w[3:0];
    endfunction

    function automatic logic [3:0] f_from(input logic [15:0] w);
        return w[7:4];
    endfunction

    function automatic logic [3:0] f_to(input logic [15:0] w);
        return w[11:8];
    endfunction

    function automatic logic [3:0] f_if(input logic [15:0] w);
        return w[15:12];
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'h4) || (op == 4'h5) || (op == 4'h7) ||
               (!MUL_EN && (op == OP_MUL));
    endfunction

endpackage

// File: rtl/cpu_seq_alu.sv
// Combinational ALU plus optional MUL_LAT-cycle multiplier (start/done).
// The multiplier exists only when CPU_SEQ_MUL_EN is defined.
module cpu_seq_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        op_i,
    input  logic [3:0]        ifld_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              mul_start_i,
    output logic [DATA_W-1:0] res_o,
    output logic              wen_o,
    output logic              mul_done_o,
    output logic [DATA_W-1:0] mul_res_o
);

    always_comb begin
        res_o = '0;
        wen_o = 1'b1;
        case (op_i)
            OP_MOV:   res_o = a_i;
            OP_MOVNZ: begin
                res_o = a_i;
                wen_o = |b_i;
            end
            OP_MOVEZ: begin
                res_o = a_i;
                wen_o = ~|b_i;
            end
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_NOT:   res_o = ~a_i;
            OP_ADD:   res_o = a_i + b_i;
            OP_SHFT:  res_o = ifld_i[3] ? (a_i << ifld_i[2:0])
                                        : (a_i >> ifld_i[2:0]);
            OP_GT:    res_o = {DATA_W{a_i > b_i}};
            OP_EQ:    res_o = {DATA_W{a_i == b_i}};
            default:  wen_o = 1'b0;
        endcase
    end

`ifdef CPU_SEQ_MUL_EN
    logic [DATA_W-1:0] prod;
    assign prod = a_i * b_i;

    if (MUL_LAT == 1) begin : g_mul_comb
        logic unused_clk;
        assign unused_clk = ^{clk, rst};
        assign mul_done_o = mul_start_i;
        assign mul_res_o  = prod;
    end else begin : g_mul_pipe
        // First stage is the product itself; done marks the last stage
        logic [DATA_W-1:0] pipe_q [MUL_LAT-1];
        logic [MUL_LAT-2:0] vld_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_q <= '0;
                for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
            end else begin
                vld_q[0]  <= mul_start_i;
                pipe_q[0] <= prod;
                for (int i = 1; i < MUL_LAT-1; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign mul_done_o = vld_q[MUL_LAT-2];
        assign mul_res_o  = pipe_q[MUL_LAT-2];
    end
`else
    logic unused_mul;
    assign unused_mul = ^{clk, rst, mul_start_i, MUL_LAT[0]};
    assign mul_done_o = 1'b0;
    assign mul_res_o  = '0;
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch, decode, operand read, execute, commit.
// Define CPU_SEQ_MUL_EN to build the multiplier for opcode D.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 2,
    parameter int PC_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic [PC_W-1:0]   pc,
    output logic              pc_inc,
    output logic [1:0]        pc_inc_amt,
    output logic [3:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    input  logic              resume,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        state_dbg
);

    state_e            state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              we_q, ill_q, mul_busy_q;
    logic [3:0]        op;
    logic              fetch_ok, mul_start, mul_done;
    logic              alu_wen;
    logic [DATA_W-1:0] alu_res, mul_res;

    assign op        = f_ins(instr_q);
    assign fetch_ok  = imem_req && imem_ack;
    assign mul_start = (state_q == EXEC) && (op == OP_MUL) && !mul_busy_q;

    cpu_seq_alu #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_alu (
        .clk         (clk),
        .rst         (rst),
        .op_i        (op),
        .ifld_i      (f_if(instr_q)),
        .a_i         (a_q),
        .b_i         (b_q),
        .mul_start_i (mul_start),
        .res_o       (alu_res),
        .wen_o       (alu_wen),
        .mul_done_o  (mul_done),
        .mul_res_o   (mul_res)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  if (fetch_ok) state_d = DECODE;
            DECODE: begin
                if (op == OP_HALT || is_illegal(op)) state_d = HALTED;
                else if (op == OP_SET)               state_d = IMM;
                else                                 state_d = RD_A;
            end
            IMM:    if (fetch_ok) state_d = COMMIT;
            RD_A:   begin
                if (op == OP_MOV || op == OP_NOT || op == OP_SHFT)
                    state_d = EXEC;
                else
                    state_d = RD_B;
            end
            RD_B:   state_d = EXEC;
            EXEC:   if (op != OP_MUL || mul_done) state_d = COMMIT;
            COMMIT: state_d = FETCH;
            HALTED: if (resume) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            we_q       <= 1'b0;
            ill_q      <= 1'b0;
            mul_busy_q <= 1'b0;
        end else begin
            mul_busy_q <= mul_start && !mul_done;
            if (state_q == FETCH && fetch_ok) instr_q <= imem_data;
            if (state_q == DECODE) ill_q <= is_illegal(op);
            if (state_q == HALTED && resume) ill_q <= 1'b0;
            if (state_q == RD_A) a_q <= reg_rdata;
            if (state_q == RD_B) b_q <= reg_rdata;
            if (state_q == IMM && fetch_ok) begin
                res_q <= DATA_W'(imem_data);
                we_q  <= 1'b1;
            end
            if (state_q == EXEC) begin
                res_q <= (op == OP_MUL) ? mul_res : alu_res;
                we_q  <= (op == OP_MUL) ? 1'b1 : alu_wen;
            end
        end
    end

    // Outputs are forced low whenever reset is held
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = '0;
        pc_inc     = 1'b0;
        pc_inc_amt = 2'd0;
        reg_raddr  = 4'd0;
        reg_we     = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                end
                DECODE: reg_raddr = f_from(instr_q);
                IMM: begin
                    imem_req  = 1'b1;
                    imem_addr = pc + PC_W'(1);
                end
                RD_A: reg_raddr = f_if(instr_q);
                COMMIT: begin
                    pc_inc     = 1'b1;
                    pc_inc_amt = (op == OP_SET) ? 2'd2 : 2'd1;
                    reg_we     = we_q;
                end
                HALTED: begin
                    halted = 1'b1;
                    if (resume) begin
                        pc_inc     = 1'b1;
                        pc_inc_amt = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_waddr = rst ? f_to(instr_q) : 4'd0;
    assign reg_wdata = rst ? res_q : '0;
    assign illegal   = rst && (state_q == HALTED) && ill_q;
    assign state_dbg = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed program bench with commit scoreboard for cpu_sequencer.
// Opcode D expectations follow CPU_SEQ_MUL_EN.
module tb_cpu_sequencer;

    localparam int DW = 16;
    localparam int ML = 2;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst, resume;
    logic          imem_ack;
    logic [15:0]   imem_data;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [PW-1:0] pc_r = '0;
    logic          pc_inc;
    logic [1:0]    pc_inc_amt;
    logic [3:0]    reg_raddr, reg_waddr;
    logic [DW-1:0] reg_rdata, reg_wdata;
    logic          reg_we, halted, illegal;
    logic [3:0]    state_dbg;

    always #5 clk = ~clk;

    cpu_sequencer #(.DATA_W(DW), .MUL_LAT(ML), .PC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .pc         (pc_r),
        .pc_inc     (pc_inc),
        .pc_inc_amt (pc_inc_amt),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .resume     (resume),
        .halted     (halted),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    typedef struct {
        logic [1:0]    amt;
        int            lat;
        logic          we;
        logic [3:0]    wa;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t          sb[$];
    logic [15:0]   imem [64];
    logic [DW-1:0] regs [16];
    int            cyc = 0;
    int            ack_cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    bit            mem_en = 1'b0;
    bit            late_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] amt, input int lat,
                        input logic we, input logic [3:0] wa,
                        input logic [DW-1:0] wd);
        exp_t e;
        e.amt = amt; e.lat = lat; e.we = we; e.wa = wa; e.wd = wd;
        sb.push_back(e);
    endtask

    // External register file and PC
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            regs[1]  <= 16'hBEEF;
            regs[6]  <= 16'h0005;
            regs[7]  <= 16'hFFFF;
            regs[8]  <= 16'h0001;
            regs[9]  <= 16'h0003;
            regs[10] <= 16'h0007;
            regs[11] <= 16'h0003;
            regs[12] <= 16'h0010;
        end else begin
            if (reg_we) regs[reg_waddr] <= reg_wdata;
            if (pc_inc) pc_r <= pc_r + PW'(pc_inc_amt);
        end
        reg_rdata <= regs[reg_raddr];
        if (imem_req && imem_ack && imem_addr == pc_r) ack_cyc <= cyc;
    end

    always @(negedge clk) begin
        imem_ack  = (mem_en && imem_req) || late_ack;
        imem_data = imem[imem_addr[5:0]];
    end

    // Commit monitor: every pc_inc must match the next scoreboard entry
    always @(negedge clk) begin
        if (pc_inc) begin
            check("pc_inc_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("pc_inc_amt", 32'(pc_inc_amt), 32'(e.amt));
                if (e.lat >= 0) check("latency", cyc - ack_cyc, e.lat);
                check("reg_we", 32'(reg_we), 32'(e.we));
                if (e.we) begin
                    check("reg_waddr", 32'(reg_waddr), 32'(e.wa));
                    check("reg_wdata", 32'(reg_wdata), 32'(e.wd));
                end
            end
        end else if (reg_we) begin
            check("we_without_pc_inc", 32'(reg_we), 0);
        end
    end

    task automatic wait_halt(input int n);
        for (int i = 0; i < n && !halted; i++) @(negedge clk);
        check("halted", 32'(halted), 1);
    endtask

    task automatic halt_step(input logic [15:0] pexp, input logic iexp);
        wait_halt(300);
        check("illegal", 32'(illegal), 32'(iexp));
        repeat (3) @(negedge clk);
        check("pc_held", 32'(pc_r), 32'(pexp));
        check("still_halted", 32'(halted), 1);
        @(posedge clk); #2 resume = 1'b1;
        @(posedge clk); #2 resume = 1'b0;
        @(negedge clk);
        check("halted_clr", 32'(halted), 0);
        check("illegal_clr", 32'(illegal), 0);
        check("pc_after_resume", 32'(pc_r), 32'(pexp) + 1);
    endtask

    initial begin
        rst = 1'b0;
        resume = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
        imem[0]  = 16'h0366; imem[1]  = 16'h1234;
        imem[2]  = 16'h4212; imem[3]  = 16'h6212;
        imem[4]  = 16'h857B; imem[5]  = 16'hAD9E;
        imem[6]  = 16'hAEAF; imem[7]  = 16'hAFBC;
        imem[8]  = 16'h2FCC; imem[9]  = 16'h4613;
        imem[10] = 16'h0031; imem[11] = 16'h099A;
        imem[12] = 16'h1878; imem[13] = 16'hCAB9;
        imem[14] = 16'hB4AD; imem[15] = 16'h0005;
        imem[16] = 16'h0021; imem[17] = 16'h0000;
        imem[18] = 16'h819B; imem[19] = 16'h0000;

        push(2, 3, 1, 4'd3,  16'h1234);
        push(1, 5, 0, 4'd0,  16'h0000);
        push(1, 5, 1, 4'd2,  16'hBEEF);
        push(1, 5, 1, 4'd5,  16'h0000);
        push(1, 5, 1, 4'd13, 16'h0000);
        push(1, 5, 1, 4'd14, 16'hFFFF);
        push(1, 4, 1, 4'd15, 16'h000C);
        push(1, 4, 1, 4'd15, 16'h0004);
        push(1, 5, 1, 4'd6,  16'hBEEF);
        push(1, 4, 1, 4'd0,  16'h1234);
        push(1, 4, 1, 4'd9,  16'hFFFC);
        push(1, 5, 1, 4'd8,  16'hBEEF);
        push(1, 5, 1, 4'd10, 16'h0013);
`ifdef CPU_SEQ_MUL_EN
        push(1, 4 + ML, 1, 4'd4, 16'h0039);
`else
        push(1, -1, 0, 4'd0, 16'h0000);
`endif
        push(1, -1, 0, 4'd0, 16'h0000);
        push(1, 4, 1, 4'd0, 16'hBEEF);
        push(1, -1, 0, 4'd0, 16'h0000);
        push(1, 5, 1, 4'd1, 16'hBEEB);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_pc_inc", 32'(pc_inc), 0);
        check("rst_we", 32'(reg_we), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_state", 32'(state_dbg), 0);
        check("rst_wdata", 32'(reg_wdata), 0);

        @(posedge clk); #2 rst = 1'b1; mem_en = 1'b1;

`ifndef CPU_SEQ_MUL_EN
        halt_step(16'd14, 1'b1);
`endif
        halt_step(16'd15, 1'b1);
        halt_step(16'd17, 1'b0);

        // Abort the ADD at pc 18 part way, with a stray ack during reset
        for (int i = 0; i < 20 && state_dbg != 4'd4; i++) @(negedge clk);
        check("reached_rd_b", 32'(state_dbg), 4);
        @(posedge clk); #2 rst = 1'b0; mem_en = 1'b0; late_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_req", 32'(imem_req), 0);
        check("abort_pc_inc", 32'(pc_inc), 0);
        check("abort_we", 32'(reg_we), 0);
        check("abort_state", 32'(state_dbg), 0);
        check("abort_addr", 32'(imem_addr), 0);
        @(posedge clk); #2 rst = 1'b1; late_ack = 1'b0;
        @(negedge clk);
        check("refetch_state", 32'(state_dbg), 0);
        check("refetch_req", 32'(imem_req), 1);
        check("refetch_addr", 32'(imem_addr), 18);
        check("refetch_pc", 32'(pc_r), 18);
        @(posedge clk); #2 mem_en = 1'b1;

        wait_halt(100);
        check("final_pc", 32'(pc_r), 19);
        check("final_illegal", 32'(illegal), 0);
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
